// File: rtl/riscv_pkg.sv
// Shared pipeline constants: opcodes, forwarding codes, hazard FSM states and the
// per-stage shadow record tracked by the hazard unit.
package riscv_pkg;

  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  localparam logic [2:0] FwdNone   = 3'd0;
  localparam logic [2:0] FwdAluRs1 = 3'd1;
  localparam logic [2:0] FwdAluRs2 = 3'd2;
  localparam logic [2:0] FwdMemRs1 = 3'd3;
  localparam logic [2:0] FwdMemRs2 = 3'd4;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StFlush   = 2'd2
  } hd_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic [6:0] op;
  } pipe_rec_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one producer record against the ID-stage source operands.
// x0 is never a producer, so a write to rd=0 cannot match.
module hazard_match (
  input  logic       i_vld,
  input  logic       i_reg_write,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_use_rs1,
  input  logic       i_use_rs2,
  output logic       o_match_rs1,
  output logic       o_match_rs2
);

  logic w_writes;

  always_comb begin
    w_writes    = i_vld && i_reg_write && (i_rd != 5'd0);
    o_match_rs1 = w_writes && i_use_rs1 && (i_rd == i_rs1);
    o_match_rs2 = w_writes && i_use_rs2 && (i_rd == i_rs2);
  end

endmodule

// File: rtl/hazard_detect.sv
// Hazard unit: tracks EX/MEM producers, generates registered forwarding codes,
// inserts a one-cycle load-use stall and flushes on taken branches.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [6:0]  id_op,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        branch_taken,
  output logic        is_hazard1,
  output logic [2:0]  hazard_reg1,
  output logic        is_hazard2,
  output logic [2:0]  hazard_reg2,
  output logic [6:0]  mem_op,
  output logic        stall,
  output logic        flush_id,
  output logic        bubble_ex,
  output logic [15:0] stall_count
);

  pipe_rec_t  r_ex, r_mem, w_ex_next;
  hd_state_e  r_state, w_state_next;

  logic       w_use_rs1, w_use_rs2;
  logic       w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic       w_load_use, w_stall, w_flush, w_bubble, w_fwd_en;
  logic       w_hz1, w_hz2;
  logic [2:0] w_code1, w_code2;
  logic [6:0] w_mem_op;

  logic       r_hz1, r_hz2;
  logic [2:0] r_code1, r_code2;
  logic [6:0] r_mem_op;
  logic [15:0] r_stall_count;

  assign w_use_rs1 = id_valid && id_use_rs1;
  assign w_use_rs2 = id_valid && id_use_rs2;

  hazard_match u_match_ex (
    .i_vld       (r_ex.valid),
    .i_reg_write (r_ex.reg_write),
    .i_rd        (r_ex.rd),
    .i_rs1       (id_rs1),
    .i_rs2       (id_rs2),
    .i_use_rs1   (w_use_rs1),
    .i_use_rs2   (w_use_rs2),
    .o_match_rs1 (w_ex_m1),
    .o_match_rs2 (w_ex_m2)
  );

  hazard_match u_match_mem (
    .i_vld       (r_mem.valid),
    .i_reg_write (r_mem.reg_write),
    .i_rd        (r_mem.rd),
    .i_rs1       (id_rs1),
    .i_rs2       (id_rs2),
    .i_use_rs1   (w_use_rs1),
    .i_use_rs2   (w_use_rs2),
    .o_match_rs1 (w_mem_m1),
    .o_match_rs2 (w_mem_m2)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    w_flush    = branch_taken && rst_n;
    w_load_use = (r_ex.op == OpLoad) && (w_ex_m1 || w_ex_m2);
    w_stall    = w_load_use && !w_flush;
    w_bubble   = w_stall || w_flush;
    // An instruction replaced by a bubble never reaches EX, so it gets no forward.
    w_fwd_en   = id_valid && !w_bubble;
  end

  always_comb begin
    w_hz1    = 1'b0;
    w_code1  = FwdNone;
    w_hz2    = 1'b0;
    w_code2  = FwdNone;
    w_mem_op = '0;
    if (w_fwd_en) begin
      if (w_ex_m1) begin
        w_hz1   = 1'b1;
        w_code1 = FwdAluRs1;
      end else if (w_ex_m2) begin
        w_hz1   = 1'b1;
        w_code1 = FwdAluRs2;
      end
      // The younger EX producer owns an operand it matches.
      if (w_mem_m1 && !w_ex_m1) begin
        w_hz2   = 1'b1;
        w_code2 = FwdMemRs1;
      end else if (w_mem_m2 && !w_ex_m2) begin
        w_hz2   = 1'b1;
        w_code2 = FwdMemRs2;
      end
      if (w_hz2) begin
        w_mem_op = r_mem.op;
      end
    end
  end

  always_comb begin
    w_ex_next.valid     = id_valid && !w_bubble;
    w_ex_next.rd        = id_rd;
    w_ex_next.reg_write = id_reg_write;
    w_ex_next.op        = id_op;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StRun:     if (w_stall) w_state_next = StLdStall;
      StLdStall: w_state_next = StRun;
      StFlush:   w_state_next = StRun;
      default:   w_state_next = StRun;
    endcase
    if (w_flush) begin
      w_state_next = StFlush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_state       <= StRun;
      r_hz1         <= 1'b0;
      r_code1       <= FwdNone;
      r_hz2         <= 1'b0;
      r_code2       <= FwdNone;
      r_mem_op      <= '0;
      r_stall_count <= '0;
    end else begin
      r_mem    <= r_ex;
      r_ex     <= w_ex_next;
      r_state  <= w_state_next;
      r_hz1    <= w_hz1;
      r_code1  <= w_code1;
      r_hz2    <= w_hz2;
      r_code2  <= w_code2;
      r_mem_op <= w_mem_op;
      if (w_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign is_hazard1  = r_hz1;
  assign hazard_reg1 = r_code1;
  assign is_hazard2  = r_hz2;
  assign hazard_reg2 = r_code2;
  assign mem_op      = r_mem_op;
  assign stall       = w_stall;
  assign flush_id    = w_flush;
  assign bubble_ex   = w_bubble;
  assign stall_count = r_stall_count;

endmodule

// File: doc/hazard_detect.md
HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: id_valid  in  1  ID holds a real instruction; id_op  in  7  ID opcode; id_rs1, id_rs2  in  5  source indices; id_use_rs1, id_use_rs2  in  1  operand actually read; id_rd  in  5  destination; id_reg_write  in  1  ID writes rd.
REQ-003 SHALL have port: branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-004 SHALL have ports: is_hazard1  out  1  EX-distance forward valid; hazard_reg1  out  3  code 1 = forward ALU to rs1, 2 = forward ALU to rs2.
REQ-005 SHALL have ports: is_hazard2  out  1  MEM-distance forward valid; hazard_reg2  out  3  code 3 = forward MEM to rs1, 4 = forward MEM to rs2.
REQ-006 SHALL have ports: mem_op  out  7  opcode of the MEM-stage producer; stall  out  1  hold PC and IF/ID; flush_id  out  1  clear IF/ID; bubble_ex  out  1  load a NOP into ID/EX.
REQ-007 SHALL have port: stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-008 SHALL keep shadow records for EX and MEM: valid, rd, reg_write, op; each record shifts ID->EX->MEM on every clock.
REQ-009 When stall=1 or bubble_ex=1, SHALL load the EX record as invalid; when stall=1, the ID inputs SHALL be held by the pipeline.
REQ-010 A match SHALL require: record valid, reg_write=1, rd!=0, rd==id_rsN, and id_use_rsN=1; x0 never matches.
REQ-011 An EX-record match on rs1 SHALL produce code 1, else a match on rs2 SHALL produce code 2 (rs1 has priority); a MEM-record match SHALL produce code 3 or 4 with the same priority.
REQ-012 When both records match the same operand, SHALL report the EX match on group 1 and suppress that operand in group 2 (youngest producer wins).
REQ-013 Forwarding outputs and mem_op SHALL be registered, with 1-cycle latency: codes computed in ID appear when the instruction enters EX; the unregistered codes used as inputs SHALL be 0/0 when id_valid=0 or stall=1.
REQ-014 Load-use: when the EX record has op=LOAD and it matches a used operand, SHALL assert stall=1 and bubble_ex=1 for exactly one cycle (FSM RUN->LDSTALL); on the next cycle the producer sits in MEM and a code of 3/4 SHALL be generated with mem_op=LOAD.
REQ-015 A JAL/JALR producer SHALL forward normally; mem_op carries its opcode so that the consumer selects pc+4.
REQ-016 FSM states: RUN, LDSTALL, FLUSH. RUN->LDSTALL on load-use; LDSTALL->RUN unconditionally; any state->FLUSH on branch_taken; FLUSH->RUN after 1 cycle.
REQ-017 On branch_taken, SHALL assert flush_id=1 and bubble_ex=1 that cycle, force stall=0, and invalidate the EX record; branch_taken SHALL override a simultaneous load-use.
REQ-018 stall_count SHALL increment on each cycle with stall=1 and saturate at 0xFFFF.

Reset
REQ-019 While rst_n=0, SHALL clear all records to invalid, FSM to RUN, and stall_count to 0, and drive all outputs to 0, asynchronously; after release, the first clk edge is normal operation.
REQ-020 Reset asserted mid-LDSTALL or mid-FLUSH SHALL abandon the sequence with no residual stall.

Structure
REQ-021 Opcode constants (LOAD, JAL, JALR), forwarding codes 1-4, and the FSM state encoding SHALL reside in the shared riscv_pkg package.
REQ-022 The register-match logic SHALL be one sub-module, hazard_match, instantiated twice (EX, MEM).

Verification
REQ-023 addi x5 then add x6,x5,x7 back-to-back -> cycle the add is in EX: is_hazard1=1, hazard_reg1=1, no stall.
REQ-024 lw x5, then add x6,x7,x5 -> stall=1 and bubble_ex=1 for 1 cycle, stall_count=1; next EX cycle is_hazard2=1, hazard_reg2=4, mem_op=LOAD.
REQ-025 addi x5,x0,1; addi x5,x0,2; add x6,x5,x5 -> hazard_reg1=1 only, is_hazard2=0.
REQ-026 addi x0,x0,1 then add x6,x0,x0 -> no hazard asserted.
REQ-027 load-use coinciding with branch_taken=1 -> flush_id=1, bubble_ex=1, stall=0, FSM=FLUSH, stall_count unchanged.
REQ-028 rst_n dropped during LDSTALL -> all outputs 0 immediately; after release, a non-dependent stream runs with no stall.
